// File: rtl/multi_debouncer.sv
// Per-channel push-button debouncer: synchroniser plus press/hold/auto-repeat/release FSM.
// Press seen SYNC_STAGES+T_SHORT+1 edges after PB rises; Moore outputs, no flow control.
module multi_debouncer #(
   parameter int N_CH        = 5,
   parameter int SYNC_STAGES = 2,
   parameter int T_SHORT     = 8_400_000,
   parameter int T_LONG      = 134_000_000,
   parameter int T_FAST      = 25_000_000,
   parameter int MCEN_BURST  = 8
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [N_CH-1:0] PB,
   input  logic [N_CH-1:0] RPT_EN,
   output logic [N_CH-1:0] DPB,
   output logic [N_CH-1:0] SCEN,
   output logic [N_CH-1:0] MCEN,
   output logic [N_CH-1:0] CCEN,
   output logic [N_CH-1:0] REL,
   output logic            ANY_DPB
);

   localparam int T_SL   = (T_SHORT > T_LONG) ? T_SHORT : T_LONG;
   localparam int T_MAX  = (T_SL > T_FAST) ? T_SL : T_FAST;
   localparam int CW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam int MW_REQ = $clog2(MCEN_BURST + 1);
   localparam int MW     = (MW_REQ > 4) ? MW_REQ : 4;

   localparam logic [2:0] INI      = 3'd0;
   localparam logic [2:0] W_PRESS  = 3'd1;
   localparam logic [2:0] PRESS    = 3'd2;
   localparam logic [2:0] HOLD     = 3'd3;
   localparam logic [2:0] RPT      = 3'd4;
   localparam logic [2:0] FAST     = 3'd5;
   localparam logic [2:0] REL_WAIT = 3'd6;
   localparam logic [2:0] RELEASE  = 3'd7;

   genvar i;
   generate
      for (i = 0; i < N_CH; i++) begin : g_ch
         logic [SYNC_STAGES-1:0] sync;
         logic                   s;
         logic [2:0]             state;
         logic [CW-1:0]          cnt;
         logic [MW-1:0]          mcnt;
         logic [MW-1:0]          mcnt_inc;

         always_ff @(posedge CLK) begin
            if (RESET) sync <= '0;
            else       sync <= {sync[SYNC_STAGES-2:0], PB[i]};
         end

         assign s        = sync[SYNC_STAGES-1];
         assign mcnt_inc = (mcnt >= MW'(MCEN_BURST)) ? MW'(MCEN_BURST) : mcnt + MW'(1);

         always_ff @(posedge CLK) begin
            if (RESET) begin
               state <= INI;
               cnt   <= '0;
               mcnt  <= '0;
            end else begin
               case (state)
                  INI: begin
                     cnt  <= '0;
                     mcnt <= '0;
                     if (s) state <= W_PRESS;
                  end
                  W_PRESS: begin
                     if (!s) begin
                        state <= INI;
                        cnt   <= '0;
                     end else if (cnt == CW'(T_SHORT - 1)) begin
                        state <= PRESS;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + CW'(1);
                     end
                  end
                  PRESS: begin
                     cnt   <= '0;
                     mcnt  <= MW'(1);
                     state <= HOLD;
                  end
                  // Counter saturates so a late RPT_EN rise repeats on the very next edge.
                  HOLD: begin
                     if (!s) begin
                        state <= REL_WAIT;
                        cnt   <= '0;
                     end else if (RPT_EN[i] && cnt == CW'(T_LONG - 1)) begin
                        state <= RPT;
                     end else if (cnt != CW'(T_LONG - 1)) begin
                        cnt <= cnt + CW'(1);
                     end
                  end
                  RPT: begin
                     mcnt  <= mcnt_inc;
                     cnt   <= '0;
                     state <= (mcnt_inc < MW'(MCEN_BURST)) ? HOLD : FAST;
                  end
                  FAST: begin
                     if (!s) begin
                        state <= REL_WAIT;
                        cnt   <= '0;
                     end else if (RPT_EN[i] && cnt == CW'(T_FAST - 1)) begin
                        state <= RPT;
                     end else if (cnt != CW'(T_FAST - 1)) begin
                        cnt <= cnt + CW'(1);
                     end
                  end
                  // Re-press during release debounce is bounce: resume holding, keep burst count.
                  REL_WAIT: begin
                     if (s) begin
                        state <= HOLD;
                        cnt   <= '0;
                     end else if (cnt == CW'(T_SHORT - 1)) begin
                        state <= RELEASE;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + CW'(1);
                     end
                  end
                  RELEASE: begin
                     state <= INI;
                     cnt   <= '0;
                  end
                  default: begin
                     state <= INI;
                     cnt   <= '0;
                     mcnt  <= '0;
                  end
               endcase
            end
         end

         assign DPB[i]  = (state == PRESS) || (state == HOLD) || (state == RPT) ||
                          (state == FAST)  || (state == REL_WAIT);
         assign CCEN[i] = DPB[i];
         assign SCEN[i] = (state == PRESS);
         assign MCEN[i] = (state == PRESS) || (state == RPT);
         assign REL[i]  = (state == RELEASE);
      end
   endgenerate

   assign ANY_DPB = |DPB;

endmodule
